// File: rtl/rhs_spi_pkg.sv
// Shared types and constants for the RHS headstage SPI responder model.
// Opcode decode and ID ROM contents live here so the bench and RTL agree.
package rhs_spi_pkg;

   typedef enum logic [2:0] {
      OP_CONVERT,
      OP_WRITE,
      OP_READ,
      OP_CALIBRATE,
      OP_CLEAR,
      OP_ILLEGAL
   } opcode_e;

   typedef enum logic [1:0] {
      ST_WAIT_HIGH,
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_e;

   localparam int FRAME_BITS = 32;
   localparam logic [5:0] BIT_SAT = 6'd33;

   localparam logic [7:0] CAL_CODE = 8'h55;
   localparam logic [7:0] CLR_CODE = 8'h6A;

   localparam logic [7:0] ROM_BASE = 8'd251;
   localparam logic [15:0] ID_ROM_0 = 16'h0049;
   localparam logic [15:0] ID_ROM_1 = 16'h004E;
   localparam logic [15:0] ID_ROM_2 = 16'h0054;
   localparam logic [15:0] ID_ROM_3 = 16'h0041;
   localparam logic [15:0] ID_ROM_4 = 16'h004E;

   localparam logic [31:0] ILLEGAL_RESULT = 32'hDEAD_BEEF;
   localparam logic [15:0] WRITE_ACK_HI = 16'hFFFF;

   function automatic opcode_e decode_op(
      input logic [31:0] cmd
   );
      opcode_e op;
      unique case (cmd[31:30])
         2'b00: op = OP_CONVERT;
         2'b10: op = OP_WRITE;
         2'b11: op = OP_READ;
         default: begin
            if (cmd[31:24] == CAL_CODE)
               op = OP_CALIBRATE;
            else if (cmd[31:24] == CLR_CODE)
               op = OP_CLEAR;
            else
               op = OP_ILLEGAL;
         end
      endcase
      return op;
   endfunction

   // "INTAN" spelled out at addresses 251..255
   function automatic logic [15:0] id_rom(
      input logic [2:0] idx
   );
      logic [15:0] v;
      unique case (idx)
         3'd0: v = ID_ROM_0;
         3'd1: v = ID_ROM_1;
         3'd2: v = ID_ROM_2;
         3'd3: v = ID_ROM_3;
         3'd4: v = ID_ROM_4;
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/rhs_spi_responder_if.sv
// SPI wires between the RHS controller (master) and the headstage model.
// All four lines are asynchronous to the responder's aclk.
interface rhs_spi_responder_if;

   logic cs_b;
   logic sclk;
   logic mosi;
   logic miso;

   modport master (
      output cs_b,
      output sclk,
      output mosi,
      input  miso
   );

   modport slave (
      input  cs_b,
      input  sclk,
      input  mosi,
      output miso
   );

endinterface

// File: rtl/rhs_spi_responder_sync_edge.sv
// Two-flop synchronizer plus a third flop for rise/fall detection.
// Edge pulses appear 3 aclk after the asynchronous input transition.
module rhs_spi_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge clk) begin
      if (rst)
         sr <= 3'b000;
      else
         sr <= {sr[1:0], din};
   end

   assign dout = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/rhs_spi_responder.sv
// RHS headstage SPI responder: 32-bit frames, two-frame result latency.
// Define RHS_SPI_ECHO_EN to return each received command word as its result.
module rhs_spi_responder
   import rhs_spi_pkg::*;
#(
   parameter int NUM_REGS  = 64,
   parameter int NUM_CH    = 16,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 aclk,
   input  logic                 areset,
   rhs_spi_responder_if.slave   spi,
   input  logic [15:0]          sample_seed,
   output logic                 cmd_valid,
   output logic [31:0]          cmd_word,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] frame_err_cnt
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic cs_s;
   logic cs_rise;
   logic cs_fall;
   logic sclk_s;
   logic sclk_rise;
   logic sclk_fall;
   logic mosi_s;
   logic mosi_rise_unused;
   logic mosi_fall_unused;
   logic sclk_s_unused;

   rhs_spi_sync_edge u_cs_sync (
      .clk  (aclk),
      .rst  (areset),
      .din  (spi.cs_b),
      .dout (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   rhs_spi_sync_edge u_sclk_sync (
      .clk  (aclk),
      .rst  (areset),
      .din  (spi.sclk),
      .dout (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   rhs_spi_sync_edge u_mosi_sync (
      .clk  (aclk),
      .rst  (areset),
      .din  (spi.mosi),
      .dout (mosi_s),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   assign sclk_s_unused = sclk_s;

   state_e state_q;
   state_e state_d;
   logic   load_tx;

   logic [31:0] rx_sr;
   logic [31:0] tx_sr;
   logic [5:0]  bit_cnt;
   logic [31:0] pipe0;
   logic [31:0] pipe1;
   logic [15:0] conv_cnt;
   logic [15:0] regs [NUM_REGS];

   opcode_e       op;
   logic [5:0]    ch;
   logic [7:0]    r_addr;
   logic [AW-1:0] r_idx;
   logic [2:0]    rom_idx;
   logic [15:0]   wdata;
   logic [31:0]   res;
   logic          wr_en;
   logic          conv_inc;
   logic          frame_ok;

   always_ff @(posedge aclk) begin
      if (areset)
         state_q <= ST_WAIT_HIGH;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load_tx = 1'b0;
      unique case (state_q)
         ST_WAIT_HIGH: begin
            if (cs_s)
               state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (cs_fall) begin
               load_tx = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_rise)
               state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_WAIT_HIGH;
      endcase
   end

   assign frame_ok = (bit_cnt == 6'(FRAME_BITS));

   // Command decode works on the fully received frame during COMMIT
   always_comb begin
      op       = decode_op(rx_sr);
      ch       = rx_sr[21:16];
      r_addr   = rx_sr[23:16];
      wdata    = rx_sr[15:0];
      r_idx    = r_addr[AW-1:0];
      rom_idx  = 3'(r_addr - ROM_BASE);
      res      = 32'h0000_0000;
      wr_en    = 1'b0;
      conv_inc = 1'b0;
      unique case (op)
         OP_CONVERT: begin
            if (int'(ch) < NUM_CH) begin
               res      = {sample_seed + {10'd0, ch}, conv_cnt};
               conv_inc = 1'b1;
            end else begin
               res = 32'hFFFF_FFFF;
            end
         end
         OP_WRITE: begin
            wr_en = (int'(r_addr) < NUM_REGS);
            res   = {WRITE_ACK_HI, wdata};
         end
         OP_READ: begin
            if (int'(r_addr) < NUM_REGS)
               res = {16'h0000, regs[r_idx]};
            else if (r_addr >= ROM_BASE)
               res = {16'h0000, id_rom(rom_idx)};
            else
               res = 32'h0000_0000;
         end
         OP_CALIBRATE: res = 32'h0000_0000;
         OP_CLEAR:     res = 32'h0000_0000;
         default:      res = ILLEGAL_RESULT;
      endcase
`ifdef RHS_SPI_ECHO_EN
      res = rx_sr;
`endif
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         rx_sr         <= '0;
         tx_sr         <= '0;
         bit_cnt       <= '0;
         pipe0         <= '0;
         pipe1         <= '0;
         conv_cnt      <= '0;
         cmd_valid     <= 1'b0;
         cmd_word      <= '0;
         frame_err     <= 1'b0;
         frame_err_cnt <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;

         if (load_tx) begin
            tx_sr   <= pipe1;
            rx_sr   <= '0;
            bit_cnt <= '0;
         end

         if (state_q == ST_SHIFT) begin
            if (sclk_rise) begin
               rx_sr <= {rx_sr[30:0], mosi_s};
               if (bit_cnt != BIT_SAT)
                  bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall)
               tx_sr <= {tx_sr[30:0], 1'b0};
         end

         if (state_q == ST_COMMIT) begin
            if (frame_ok) begin
               pipe1     <= pipe0;
               pipe0     <= res;
               cmd_valid <= 1'b1;
               cmd_word  <= rx_sr;
               if (wr_en)
                  regs[r_idx] <= wdata;
               if (conv_inc)
                  conv_cnt <= conv_cnt + 16'd1;
            end else begin
               frame_err <= 1'b1;
               if (frame_err_cnt != '1)
                  frame_err_cnt <= frame_err_cnt + ERR_CNT_W'(1);
            end
         end
      end
   end

   assign spi.miso = (state_q == ST_SHIFT) & tx_sr[31];

endmodule

// File: tb/tb_rhs_spi_responder.sv
// Bench for rhs_spi_responder: SPI master tasks push expected MISO words,
// independent monitors pop and compare on frame end and on cmd_valid.
module tb_rhs_spi_responder;

   localparam int HALF = 50;

   typedef struct {
      logic [31:0] exp;
      bit          chk;
   } exp_t;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [15:0] sample_seed = 16'h0000;
   logic        cmd_valid;
   logic [31:0] cmd_word;
   logic        frame_err;
   logic [15:0] frame_err_cnt;

   rhs_spi_responder_if spi ();

   rhs_spi_responder #(
      .NUM_REGS  (64),
      .NUM_CH    (16),
      .ERR_CNT_W (16)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .spi           (spi),
      .sample_seed   (sample_seed),
      .cmd_valid     (cmd_valid),
      .cmd_word      (cmd_word),
      .frame_err     (frame_err),
      .frame_err_cnt (frame_err_cnt)
   );

   always #5 aclk = ~aclk;

   exp_t        miso_q [$];
   logic [31:0] cmd_q [$];
   int n_chk   = 0;
   int n_pass  = 0;
   int n_valid = 0;
   int n_err   = 0;
   int n_frame = 0;

   function automatic void check(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endfunction

   task automatic do_reset();
      @(negedge aclk);
      areset = 1'b1;
      repeat (4) @(negedge aclk);
      areset = 1'b0;
      #100;
   endtask

   task automatic spi_frame(
      input logic [31:0] w,
      input int          nbits,
      input logic [31:0] exp,
      input bit          chk_miso,
      input int          rst_at
   );
      exp_t e;
      if (nbits == 32) begin
         e.exp = exp;
         e.chk = chk_miso;
         miso_q.push_back(e);
         if (rst_at < 0)
            cmd_q.push_back(w);
      end
      spi.cs_b = 1'b0;
      #HALF;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            areset = 1'b1;
            #40;
            areset = 1'b0;
         end
         spi.mosi = w[31 - (i % 32)];
         #HALF spi.sclk = 1'b1;
         #HALF spi.sclk = 1'b0;
      end
      #HALF spi.cs_b = 1'b1;
      spi.mosi = 1'b0;
      #200;
   endtask

   task automatic full(input logic [31:0] w, input logic [31:0] exp);
      spi_frame(w, 32, exp, 1'b1, -1);
   endtask

   // MISO monitor: reassembles each frame as the master would see it
   initial begin
      logic [31:0] sh;
      int          nb;
      exp_t        e;
      forever begin
         @(negedge spi.cs_b);
         sh = '0;
         nb = 0;
         while (spi.cs_b === 1'b0) begin
            @(posedge spi.sclk or posedge spi.cs_b);
            if (spi.cs_b === 1'b0) begin
               sh = {sh[30:0], spi.miso};
               nb++;
            end
         end
         if (nb == 32) begin
            n_frame++;
            if (miso_q.size() == 0) begin
               n_chk++;
               $display("FAIL miso_unexpected: got 0x%08h, expected no frame", sh);
            end else begin
               e = miso_q.pop_front();
               if (e.chk)
                  check($sformatf("miso_frame%0d", n_frame), sh, e.exp);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge aclk);
         if (frame_err === 1'b1)
            n_err++;
         if (cmd_valid === 1'b1) begin
            n_valid++;
            if (cmd_q.size() == 0) begin
               n_chk++;
               $display("FAIL cmd_unexpected: got 0x%08h, expected no commit", cmd_word);
            end else begin
               check("cmd_word", cmd_word, cmd_q.pop_front());
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int v0;
      int e0;
      spi.cs_b = 1'b1;
      spi.sclk = 1'b0;
      spi.mosi = 1'b0;
      areset   = 1'b1;
      repeat (4) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      check("rst_miso", 32'(spi.miso), 32'h0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
      check("rst_cmd_word", cmd_word, 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_err_cnt", 32'(frame_err_cnt), 32'h0);
      #100;

`ifdef RHS_SPI_ECHO_EN
      full(32'h1234_5678, 32'h0);
      full(32'h9ABC_DEF0, 32'h0);
      full(32'h0000_0000, 32'h1234_5678);
      full(32'h6A00_0000, 32'h9ABC_DEF0);
`else
      // ID ROM reads and the two-frame latency
      full(32'hC0FB_0000, 32'h0);
      full(32'hC0FC_0000, 32'h0);
      full(32'hC0FD_0000, 32'h0000_0049);
      full(32'hC0FE_0000, 32'h0000_004E);

      // write then immediate read-back
      do_reset();
      full(32'h8005_80FF, 32'h0);
      full(32'hC005_0000, 32'h0);
      full(32'h0000_0000, 32'hFFFF_80FF);
      full(32'h6A00_0000, 32'h0000_80FF);

      // CONVERT with out-of-range channel, then CAL/illegal
      do_reset();
      sample_seed = 16'h1000;
      v0 = n_valid;
      full(32'h0003_0000, 32'h0);
      full(32'h0011_0000, 32'h0);
      full(32'h0003_0000, 32'h1003_0000);
      full(32'h6A00_0000, 32'hFFFF_FFFF);
      full(32'h6A00_0000, 32'h1003_0001);
      check("cmd_valid_pulses", 32'(n_valid - v0), 32'd5);
      full(32'h5500_0000, 32'h0);
      full(32'h4000_0000, 32'h0);
      full(32'h6A00_0000, 32'h0);
      full(32'h6A00_0000, 32'hDEAD_BEEF);

      // aborted frames leave the pipeline alone
      do_reset();
      e0 = n_err;
      full(32'hC0FB_0000, 32'h0);
      full(32'hC0FC_0000, 32'h0);
      spi_frame(32'hC0FD_0000, 20, 32'h0, 1'b0, -1);
      repeat (3) begin
         #HALF spi.sclk = 1'b1;
         #HALF spi.sclk = 1'b0;
      end
      full(32'hC0FB_0000, 32'h0000_0049);
      check("err_cnt_after_20b", 32'(frame_err_cnt), 32'd1);
      check("err_pulses_20b", 32'(n_err - e0), 32'd1);
      spi_frame(32'h0, 0, 32'h0, 1'b0, -1);
      spi_frame(32'hC0FE_0000, 33, 32'h0, 1'b0, -1);
      full(32'hC0FD_0000, 32'h0000_004E);
      check("err_cnt_after_0b_33b", 32'(frame_err_cnt), 32'd3);
      check("err_pulses_total", 32'(n_err - e0), 32'd3);

      // reset in the middle of a frame with cs_b held low
      e0 = n_err;
      v0 = n_valid;
      spi_frame(32'hC0FB_0000, 32, 32'h0, 1'b0, 12);
      full(32'h8007_1234, 32'h0);
      full(32'hC007_0000, 32'h0);
      full(32'h0001_0000, 32'hFFFF_1234);
      check("midrst_err_pulses", 32'(n_err - e0), 32'd0);
      check("midrst_err_cnt", 32'(frame_err_cnt), 32'd0);
      check("midrst_cmd_valid", 32'(n_valid - v0), 32'd3);
`endif

      #1000;
      check("miso_q_drained", 32'(miso_q.size()), 32'd0);
      check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rhs_spi_responder.md
Name: rhs_spi_responder

Overview:
Synthesizable SPI responder that models the RHS stim/record headstage chip as seen by our RHS SPI controller (outputs CS_b, SCLK, MOSI).
- Deserializes 32-bit command frames and decodes CONVERT, READ, WRITE, CALIBRATE and CLEAR.
- Holds a register file and returns each frame's result on MISO two frames later.
- Placed in the rhs_axi_tb block design opposite the controller, so loopback-free closed-loop simulation and FPGA self-test are possible.

Parameters:
NUM_REGS, 64, number of writable 16-bit registers at addresses 0..NUM_REGS-1
NUM_CH, 16, valid CONVERT channels 0..NUM_CH-1
ERR_CNT_W, 16, width of the saturating frame-error counter

Ports:
aclk  in  1  system clock; must run at least 8x SCLK frequency
areset  in  1  synchronous reset, active-high
cs_b  in  1  SPI chip select, active-low, asynchronous to aclk
sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous
mosi  in  1  SPI data in, MSB first
miso  out  1  SPI data out, MSB first
sample_seed  in  16  base value for synthetic CONVERT data
cmd_valid  out  1  one-cycle pulse when a complete frame is committed
cmd_word  out  32  last committed command word
frame_err  out  1  one-cycle pulse when a frame is aborted with bit count != 32
frame_err_cnt  out  ERR_CNT_W  count of aborted frames, saturating

Behaviour:
- Reset values: miso=0, cmd_valid=0, cmd_word=0, frame_err=0, frame_err_cnt=0. Registers, result pipeline, conv_cnt and bit counter are all 0.
- Input synchronization: cs_b, sclk and mosi each pass through a 2-FF synchronizer. Edge detect is done on the synchronized sclk and cs_b. Sync-plus-edge latency is 3 aclk.
- State machine:
  - WAIT_HIGH: entered from reset. Goes to IDLE once cs_b is seen high; a frame already in progress at reset is ignored.
  - IDLE: on cs_b fall, load the TX shifter with pipe[1] and go to SHIFT. miso shows bit 31 within 3 aclk of the cs_b fall.
  - SHIFT:
    - On each sclk rise, shift mosi into rx_sr and increment bit_cnt (6 bits, saturates at 33).
    - On each sclk fall, shift the TX shifter left, so miso presents the next bit.
    - On cs_b rise, go to COMMIT.
  - COMMIT (1 cycle):
    - If bit_cnt==32: decode rx_sr, then pipe[1]<=pipe[0] and pipe[0]<=result. Pulse cmd_valid and set cmd_word<=rx_sr.
    - Otherwise: pulse frame_err, increment frame_err_cnt (saturating), leave the pipeline unchanged.
    - In both cases, next state is IDLE.
- miso is 0 whenever cs_b is high.
- Decode of cmd[31:0]:
  - CONVERT, [31:30]=00, channel ch=[21:16]:
    - Result = {sample_seed + ch, conv_cnt}, where the addition is 16-bit modulo.
    - conv_cnt increments after each CONVERT and wraps at 0xFFFF.
    - If ch >= NUM_CH, the result is 0xFFFF_FFFF and conv_cnt is unchanged.
  - WRITE, [31:30]=10, address R=[23:16], data D=[15:0]:
    - If R < NUM_REGS, reg[R]<=D; otherwise the write is ignored.
    - Result = {16'hFFFF, D} in both cases.
  - READ, [31:30]=11, address R=[23:16]:
    - Result = {16'h0000, val}.
    - val = reg[R] if R < NUM_REGS.
    - val = ROM for R=251..255: 0x0049, 0x004E, 0x0054, 0x0041, 0x004E ("INTAN").
    - val = 0 otherwise.
  - CALIBRATE: [31:24]=0x55. Result 0x0000_0000.
  - CLEAR: [31:24]=0x6A. Result 0x0000_0000.
  - Any other [31:30]=01 word: result 0xDEAD_BEEF.
- Latency: the result of frame n is shifted out during frame n+2. The first two frames after reset return 0x0000_0000.
- Boundary conditions:
  - WRITE then READ of the same R in consecutive frames: the READ returns the new value.
  - More than 32 sclk rises: bit_cnt saturates at 33 and the frame aborts at cs_b rise.
  - cs_b rise with 0 bits: counted as an error.
  - sclk edges while cs_b is high: ignored.
  - Reset mid-frame: everything is cleared and the state is WAIT_HIGH.

Optional Feature:
RHS_SPI_ECHO_EN
- Defined: every committed frame's result is replaced by the raw received command word, so the same 2-frame latency applies (echo mode). The register file is still written by WRITE commands.
- Undefined: decode behaviour as described above; echo logic is absent.

Decomposition:
- Package rhs_spi_pkg:
  - Opcode enum (CONVERT, WRITE, READ, CALIBRATE, CLEAR, ILLEGAL).
  - FRAME_BITS=32, CAL_CODE=8'h55, CLR_CODE=8'h6A.
  - ID ROM constants, ILLEGAL_RESULT=32'hDEAD_BEEF, WRITE_ACK_HI=16'hFFFF.
  - Decode function returning opcode.
- Sub-module rhs_spi_sync_edge: 2-FF synchronizer with rise/fall pulse outputs. Instantiated for cs_b and sclk; the mosi instance leaves the edge outputs unused.

Test Plan:
- Reset, then send READ 251, READ 252, READ 253, READ 254 -> MISO returns 0, 0, 0x00000049, 0x0000004E.
- WRITE R=5 D=0x80FF, READ 5, CONVERT ch0 -> frames 3 and 4 return 0xFFFF80FF and 0x000080FF.
- sample_seed=0x1000; CONVERT ch3, ch17, ch3, CLEAR, CLEAR:
  - Frames 3-5 return 0x10030000, 0xFFFFFFFF, 0x10030001.
  - cmd_valid pulses 5 times.
- Send 20-bit frame, then a full 32-bit READ 251:
  - frame_err pulses once and frame_err_cnt=1.
  - Pipeline unchanged (the READ returns the result from 2 valid frames prior).
- Assert areset mid-frame at bit 12, release with cs_b still low, complete the frame, then send 3 valid frames:
  - The partial frame produces no cmd_valid and no frame_err.
  - The next frames return 0, 0, then the first valid frame's result.
- With RHS_SPI_ECHO_EN defined, send 0x12345678, 0x9ABCDEF0, 0 -> the third frame returns 0x12345678.
